// File: rtl/magnetron_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | magnetron_pkg : shared BCD constants for the cook-time countdown   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package magnetron_pkg;

    localparam int              BCD_W        = 4;
    localparam logic [BCD_W-1:0] BCD_MAX      = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] BCD_ZERO     = 4'd0;

endpackage : magnetron_pkg
`default_nettype wire

// File: rtl/magnetron_timer_bcd_down_digit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bcd_down_digit : one BCD digit register with decrement-and-borrow  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bcd_down_digit
    import magnetron_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAXV = BCD_MAX
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             dec_en,
    input  logic             load_en,
    input  logic [BCD_W-1:0] load_val,
    output logic [BCD_W-1:0] q,
    output logic             borrow_out
);

    logic [BCD_W-1:0] q_q;
    logic [BCD_W-1:0] q_d;

    // Clear outranks decrement, which outranks a digit shift-in.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = BCD_ZERO;
        end else if (dec_en) begin
            q_d = (q_q == BCD_ZERO) ? MAXV : q_q - 4'd1;
        end else if (load_en) begin
            q_d = load_val;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_q <= BCD_ZERO;
        end else begin
            q_q <= q_d;
        end
    end

    assign q          = q_q;
    assign borrow_out = dec_en && (q_q == BCD_ZERO);

endmodule : bcd_down_digit
`default_nettype wire

// File: rtl/magnetron_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | magnetron_timer : M:SS BCD cook-time entry and 1 Hz countdown      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module magnetron_timer
    import magnetron_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int PRE_W  = $clog2(CLK_HZ)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clearn,
    input  logic             loadn,
    input  logic [BCD_W-1:0] digit,
    input  logic             magnetron_on,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             tick,
    output logic             timer_done
);

    logic             loadn_q;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    logic             w_wrap;
    logic             w_load;
    logic             w_accept;
    logic             w_dec;
    logic             w_borrow_ones;
    logic             w_borrow_tens;
    logic             w_borrow_min;

    assign w_wrap = magnetron_on && clearn && (pre_q == PRE_W'(CLK_HZ - 1));
    assign tick   = w_wrap;

    // A pause or clear throws away the partial second.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        if (!clearn || !magnetron_on || w_wrap) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q   <= '0;
            loadn_q <= 1'b1;
        end else begin
            pre_q   <= pre_d;
            loadn_q <= loadn;
        end
    end

    assign w_load   = loadn_q && !loadn;
    // sec_ones must fit the tens position it is about to move into.
    assign w_accept = w_load && !magnetron_on && clearn &&
                      (digit <= BCD_MAX) && (sec_ones <= SEC_TENS_MAX);

    assign timer_done = (min_ones == BCD_ZERO) && (sec_tens == BCD_ZERO) &&
                        (sec_ones == BCD_ZERO);
    assign w_dec      = w_wrap && !timer_done;

    bcd_down_digit #(.MAXV(BCD_MAX)) u_sec_ones (
        .clk        (clk),
        .resetn     (resetn),
        .clr        (!clearn),
        .dec_en     (w_dec),
        .load_en    (w_accept),
        .load_val   (digit),
        .q          (sec_ones),
        .borrow_out (w_borrow_ones)
    );

    bcd_down_digit #(.MAXV(SEC_TENS_MAX)) u_sec_tens (
        .clk        (clk),
        .resetn     (resetn),
        .clr        (!clearn),
        .dec_en     (w_borrow_ones),
        .load_en    (w_accept),
        .load_val   (sec_ones),
        .q          (sec_tens),
        .borrow_out (w_borrow_tens)
    );

    // Never borrows out: a borrow here would need 0:00, which blocks w_dec.
    bcd_down_digit #(.MAXV(BCD_MAX)) u_min_ones (
        .clk        (clk),
        .resetn     (resetn),
        .clr        (!clearn),
        .dec_en     (w_borrow_tens),
        .load_en    (w_accept),
        .load_val   (sec_tens),
        .q          (min_ones),
        .borrow_out (w_borrow_min)
    );

    logic w_unused;
    assign w_unused = w_borrow_min;

endmodule : magnetron_timer
`default_nettype wire

// File: tb/tb_magnetron_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_magnetron_timer : randomized + directed bench, seconds-based model|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_magnetron_timer;

    localparam int CLK_HZ = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       clearn = 1'b1;
    logic       loadn = 1'b1;
    logic [3:0] digit = 4'd0;
    logic       magnetron_on = 1'b0;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       tick;
    logic       timer_done;

    int total = 0;
    int bad   = 0;

    // Model: remaining time in seconds, cycles into the current second.
    int m_t    = 0;
    int m_cnt  = 0;
    bit m_prev = 1'b1;
    bit rst_pending = 1'b0;
    bit last_tick = 1'b0;

    magnetron_timer #(.CLK_HZ(CLK_HZ)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .clearn       (clearn),
        .loadn        (loadn),
        .digit        (digit),
        .magnetron_on (magnetron_on),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .tick         (tick),
        .timer_done   (timer_done)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int t);
        logic [3:0] m, st, so;
        m  = 4'(t / 60);
        st = 4'((t % 60) / 10);
        so = 4'(t % 10);
        return {m, st, so};
    endfunction

    task automatic model_reset();
        m_t    = 0;
        m_cnt  = 0;
        m_prev = 1'b1;
    endtask

    task automatic lit(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Compare at the falling edge, then advance the model across the next rising edge.
    task automatic cycle();
        logic [11:0] got_t;
        logic [11:0] exp_t;
        bit          exp_tick;
        bit          ld;
        @(negedge clk);
        if (rst_pending) begin
            model_reset();
            rst_pending = 1'b0;
        end
        if (!resetn) model_reset();
        exp_tick = resetn && clearn && magnetron_on && (m_cnt == CLK_HZ - 1);
        exp_t    = to_bcd(m_t);
        got_t    = {min_ones, sec_tens, sec_ones};
        total++;
        if (got_t !== exp_t || timer_done !== (m_t == 0) || tick !== exp_tick) begin
            bad++;
            $display("FAIL cycle@%0t: time=%h done=%b tick=%b expected time=%h done=%b tick=%b",
                     $time, got_t, timer_done, tick, exp_t, (m_t == 0), exp_tick);
        end
        last_tick = tick;
        if (resetn) begin
            ld = m_prev && !loadn;
            if (!clearn) begin
                m_t   = 0;
                m_cnt = 0;
            end else if (magnetron_on) begin
                if (m_cnt == CLK_HZ - 1) begin
                    m_cnt = 0;
                    if (m_t > 0) m_t = m_t - 1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                m_cnt = 0;
                if (ld && digit <= 4'd9 && (m_t % 10) <= 5)
                    m_t = ((m_t % 60) / 10) * 60 + (m_t % 10) * 10 + int'(digit);
            end
            m_prev = loadn;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic enter(input logic [3:0] d);
        digit = d;
        loadn = 1'b0;
        cycle();
        loadn = 1'b1;
        cycle();
    endtask

    task automatic do_clear();
        clearn = 1'b0;
        cycle();
        clearn = 1'b1;
    endtask

    function automatic int now_bcd();
        return int'({min_ones, sec_tens, sec_ones});
    endfunction

    initial begin
        cycles(2);
        lit("reset_time", now_bcd(), 'h000);
        lit("reset_done", int'(timer_done), 1);
        lit("reset_tick", int'(tick), 0);
        resetn = 1'b1;
        cycle();

        enter(4'd1); enter(4'd3); enter(4'd0);
        lit("load_130", now_bcd(), 'h130);
        lit("load_130_done", int'(timer_done), 0);
        lit("model_130", m_t, 90);

        do_clear();
        enter(4'd0); enter(4'd0); enter(4'd2);
        lit("load_002", now_bcd(), 'h002);
        magnetron_on = 1'b1;
        cycles(3);
        lit("no_tick_3", int'(last_tick), 0);
        cycle();
        lit("tick_4", int'(last_tick), 1);
        lit("after_4", now_bcd(), 'h001);
        cycles(4);
        lit("after_8", now_bcd(), 'h000);
        lit("done_8", int'(timer_done), 1);
        cycles(4);
        lit("tick_12", int'(last_tick), 1);
        lit("hold_000", now_bcd(), 'h000);
        magnetron_on = 1'b0;

        do_clear();
        enter(4'd1); enter(4'd0); enter(4'd0);
        magnetron_on = 1'b1;
        cycles(4);
        lit("borrow_100", now_bcd(), 'h059);
        magnetron_on = 1'b0;
        do_clear();
        enter(4'd1); enter(4'd0);
        magnetron_on = 1'b1;
        cycles(4);
        lit("borrow_010", now_bcd(), 'h009);
        magnetron_on = 1'b0;

        do_clear();
        enter(4'd5);
        magnetron_on = 1'b1; cycles(3);
        magnetron_on = 1'b0; cycles(2);
        magnetron_on = 1'b1; cycles(3);
        lit("pause_005", now_bcd(), 'h005);
        cycle();
        lit("resume_004", now_bcd(), 'h004);
        magnetron_on = 1'b0;

        do_clear();
        enter(4'hA);
        lit("illegal_A", now_bcd(), 'h000);
        enter(4'd9);
        lit("enter_9", now_bcd(), 'h009);
        enter(4'd0);
        lit("reject_90", now_bcd(), 'h009);
        do_clear();
        digit = 4'd2;
        loadn = 1'b0;
        cycles(10);
        loadn = 1'b1;
        cycle();
        lit("hold_low", now_bcd(), 'h002);
        magnetron_on = 1'b1;
        enter(4'd3);
        lit("load_while_on", now_bcd(), 'h002);
        magnetron_on = 1'b0;

        do_clear();
        enter(4'd4); enter(4'd5);
        magnetron_on = 1'b1;
        cycles(2);
        clearn = 1'b0;
        cycle();
        lit("clear_mid", now_bcd(), 'h000);
        lit("clear_done", int'(timer_done), 1);
        clearn = 1'b1;
        magnetron_on = 1'b0;
        enter(4'd3);
        magnetron_on = 1'b1;
        cycles(4);
        lit("pre_zeroed", now_bcd(), 'h002);
        magnetron_on = 1'b0;
        digit = 4'd7;
        loadn = 1'b0;
        clearn = 1'b0;
        cycle();
        lit("clear_vs_load", now_bcd(), 'h000);
        loadn = 1'b1;
        clearn = 1'b1;
        cycle();

        enter(4'd4); enter(4'd5);
        magnetron_on = 1'b1;
        cycles(2);
        #1 resetn = 1'b0;
        #1;
        lit("async_time", now_bcd(), 'h000);
        lit("async_done", int'(timer_done), 1);
        rst_pending = 1'b1;
        #1 resetn = 1'b1;
        magnetron_on = 1'b0;
        cycle();

        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom_range(0, 299) != 0);
            clearn = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 11) == 0) magnetron_on = ~magnetron_on;
            loadn  = 1'($urandom_range(0, 1));
            digit  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_magnetron_timer
`default_nettype wire

// File: doc/magnetron_timer.md
Name: magnetron_timer

Overview:
- Cook-time countdown block for the microwave magnetron controller.
- Accepts BCD digits from the keypad path and holds an M:SS time.
- Counts down once per second while the magnetron is energised.
- Drives timer_done, which the set/reset logic consumes to start and stop the magnetron latch.

Parameters:
- CLK_HZ, 50000000, clk cycles per one-second tick. Benches override with a small value, e.g. 4.
- PRE_W, $clog2(CLK_HZ), prescaler width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- clearn  input  1  synchronous active-low clear from the Clear button, level sensitive
- loadn  input  1  active-low digit strobe; falling edge enters one digit
- digit  input  4  BCD digit presented with loadn
- magnetron_on  input  1  magnetron latch output; enables countdown
- min_ones  output  4  minutes digit, BCD 0-9
- sec_tens  output  4  tens-of-seconds digit, BCD 0-5
- sec_ones  output  4  seconds digit, BCD 0-9
- tick  output  1  one-cycle pulse on each one-second decrement event
- timer_done  output  1  high when time is 0:00

Behaviour:
- Reset (resetn=0, async):
  - all digits 0, prescaler 0, tick 0.
  - loadn_q = 1.
  - timer_done = 1, so the magnetron cannot be set until time is entered.
- timer_done: combinational decode of the registered digits, (min_ones, sec_tens, sec_ones) == 0. No extra latency.
- Load event:
  - load = loadn_q & ~loadn, where loadn_q is loadn registered each cycle.
  - Acts once per falling edge; a held-low loadn loads once.
- Digit entry on a load event, accepted only if all of:
  - magnetron_on = 0
  - clearn = 1
  - digit <= 9
  - current sec_ones <= 5, because it moves into the tens-of-seconds position
- Accepted entry shifts left in one cycle: min_ones <= sec_tens, sec_tens <= sec_ones, sec_ones <= digit.
- A rejected entry changes nothing.
- Prescaler:
  - Counts when magnetron_on = 1.
  - Forced to 0 in any cycle with magnetron_on = 0 or clearn = 0. A pause discards the partial second.
- Tick generation:
  - When the prescaler equals CLK_HZ-1 with magnetron_on = 1, it wraps to 0 and tick = 1 that cycle.
  - First tick arrives on the CLK_HZ-th consecutive on-cycle.
- Decrement on tick, applied on the same clock edge that wraps the prescaler:
  - sec_ones: 0 -> 9 with borrow, else -1.
  - sec_tens: decrements only on borrow; 0 -> 5 with borrow, else -1.
  - min_ones: decrements only on borrow from sec_tens.
- At 0:00 a tick leaves the digits unchanged (no wrap to 9:59); tick still pulses.
- Clear: clearn = 0 zeroes all digits and the prescaler on the next edge.
- Priority, highest first: resetn, clearn, tick-decrement, load.
  - Tick and an accepted load cannot coincide, since load requires magnetron_on = 0.
- Reset mid-count: all state returns to reset values immediately, independent of clk.
- Range: max 9:59. Digit values >9, and tens values >5, are unreachable.

Decomposition:
- Shared package magnetron_pkg:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - SEC_TENS_MAX = 4'd5
  - BCD_ZERO = 4'd0
- Sub-module bcd_down_digit, one BCD digit register with a decrement-with-borrow rule:
  - Parameter MAXV (9 or 5).
  - Inputs: dec_en, load_en, load_val, clr.
  - Outputs: q, borrow_out (dec_en && q == 0).
  - Instantiated three times, with borrows chained.
- Top level holds the prescaler, loadn edge detector, entry validation and the done decode.

Test Plan (CLK_HZ = 4):
- Reset then release -> all digits 0, timer_done = 1, tick = 0. Load 1, 3, 0 with loadn pulses -> 1:30, timer_done = 0.
- Load 0, 0, 2 then magnetron_on = 1:
  - tick on the 4th on-cycle -> 0:01.
  - tick on the 8th on-cycle -> 0:00, timer_done = 1.
  - 12th on-cycle: tick = 1, digits stay 0:00.
- 1:00 with magnetron_on = 1 for 4 cycles -> 0:59. 0:10 -> one tick -> 0:09.
- Pause and resume from 0:05:
  - on 3 cycles, off 2, on 3 -> still 0:05, no tick.
  - 4th cycle of the second on-window -> 0:04.
- Illegal entry, starting from 0:00:
  - digit = 4'hA -> ignored.
  - digit = 9 -> 0:09.
  - digit = 0 next -> rejected (9 cannot enter sec_tens), stays 0:09.
  - loadn held low 10 cycles -> one entry only.
  - load while magnetron_on = 1 -> ignored.
- Clear and async reset during countdown:
  - clearn = 0 at 0:45 mid-second -> 0:00 next edge, prescaler 0, timer_done = 1.
  - clearn = 0 together with a load edge -> clear wins.
  - resetn pulse between clock edges -> outputs reset without waiting for clk.
